// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - non-overlapped instruction fetch stage with retired-instruction counter
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_fault,
    output logic [31:0] instret,
    output logic        spurious_wb
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_RETIRE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_o_pc;
    logic [31:0] r_o_instr;
    logic        r_o_fault;
    logic [31:0] r_instret;
    logic        r_spurious;
    logic        w_misaligned;

    assign w_misaligned = |r_pc[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // The request is gated by rst so nothing is offered to memory while held in reset.
    always_comb begin
        w_next         = r_state;
        imem_req_valid = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_misaligned) begin
                    w_next = S_ISSUE;
                end else begin
                    imem_req_valid = rst;
                    if (imem_req_ready) begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (o_ready) begin
                    w_next = S_RETIRE;
                end
            end
            S_RETIRE: begin
                if (wb_valid) begin
                    w_next = S_FETCH;
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_o_pc     <= 32'h0;
            r_o_instr  <= 32'h0;
            r_o_fault  <= 1'b0;
            r_instret  <= 32'h0;
            r_spurious <= 1'b0;
        end else begin
            if (r_state == S_FETCH && w_misaligned) begin
                r_o_pc    <= r_pc;
                r_o_instr <= NOP_INSTR;
                r_o_fault <= 1'b1;
            end
            if (r_state == S_WAIT && imem_rsp_valid) begin
                r_o_pc    <= r_pc;
                r_o_instr <= imem_rsp_err ? NOP_INSTR : imem_rsp_data;
                r_o_fault <= imem_rsp_err;
            end
            // A commit outside RETIRE (including the decode-handshake cycle) is flagged, not applied.
            if (wb_valid) begin
                if (r_state == S_RETIRE) begin
                    r_pc      <= wb_pc;
                    r_instret <= r_instret + 32'd1;
                end else begin
                    r_spurious <= 1'b1;
                end
            end
        end
    end

    assign imem_req_addr = r_pc;
    assign o_valid       = (r_state == S_ISSUE);
    assign o_pc          = r_o_pc;
    assign o_instr       = r_o_instr;
    assign o_fault       = r_o_fault;
    assign instret       = r_instret;
    assign spurious_wb   = r_spurious;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that closes the loop with the writeback stage.
- Consumes the committed next-PC published by writeback, fetches the instruction at that address over a valid/ready instruction-memory interface, and presents {pc, instr} to decode with a valid/ready handshake.
- Machine is non-overlapped: exactly one instruction in flight between fetch and writeback.
- Also maintains the retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction word substituted on any fetch fault (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_valid  input  1  writeback commit strobe (writeback output valid).
- wb_pc  input  32  next PC computed by writeback; sampled only with wb_valid.
- imem_req_valid  output  1  instruction memory request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  32  word address of the request (byte address, [1:0]=0).
- imem_rsp_valid  input  1  response valid; never in the same cycle as the request handshake.
- imem_rsp_data  input  32  instruction word.
- imem_rsp_err  input  1  bus error qualifying imem_rsp_valid.
- o_valid  output  1  instruction available to decode.
- o_ready  input  1  decode accepts.
- o_pc  output  32  PC of the presented instruction.
- o_instr  output  32  instruction word (NOP_INSTR on fault).
- o_fault  output  1  1 = misaligned PC or bus error for this instruction.
- instret  output  32  count of accepted wb_valid commits, wraps modulo 2^32.
- spurious_wb  output  1  sticky flag: wb_valid seen outside RETIRE.

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, pc=RESET_PC.
  - imem_req_valid=0 while in reset; it rises in the first cycle after deassertion.
  - o_valid=0, o_pc=0, o_instr=0, o_fault=0, instret=0, spurious_wb=0.
  - Reset mid-transaction aborts it. A response arriving after reset release while in FETCH is ignored.
- FSM states and transitions:
  - FETCH:
    - If pc[1:0]!=0: no request issued; load o_pc=pc, o_instr=NOP_INSTR, o_fault=1; next state ISSUE.
    - Else drive imem_req_valid=1 and imem_req_addr=pc, both held stable until imem_req_ready. On the handshake, go to WAIT.
  - WAIT: on imem_rsp_valid, register o_pc=pc; o_instr=err ? NOP_INSTR : imem_rsp_data; o_fault=err; next state ISSUE.
  - ISSUE: o_valid=1, with o_pc/o_instr/o_fault held stable. On o_valid&o_ready, go to RETIRE; o_valid drops the next cycle.
  - RETIRE: wait for wb_valid. On wb_valid: pc<=wb_pc, instret<=instret+1, next state FETCH.
- Minimum latency: request handshake in cycle N, response in N+1, o_valid in N+2. wb_valid to imem_req_valid is 1 cycle.
- Ignored events:
  - imem_rsp_valid outside WAIT is ignored (not buffered).
  - wb_valid outside RETIRE is ignored for pc and instret, and sets spurious_wb=1 (cleared only by reset).
  - wb_valid in the same cycle as the ISSUE→RETIRE handshake counts as spurious.
- wb_pc is used unmodified; misalignment is detected in FETCH, not at capture.
- o_ready while o_valid=0 has no effect.

Test Plan:
- Reset release, RESET_PC=0, ready=1, rsp 0x00500093 one cycle later -> req addr 0x0 in cycle 1; o_valid in cycle 3 with o_pc=0, o_instr=0x00500093, o_fault=0.
- Accept, then wb_valid with wb_pc=0x10 -> next request addr=0x10 one cycle later; instret=1.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid and addr stable throughout; WAIT entered only after ready=1.
- wb_pc=0x22 -> no memory request; o_valid with o_pc=0x22, o_instr=0x00000013, o_fault=1.
- Response with err=1, data=0xDEADBEEF -> o_instr=0x00000013, o_fault=1. o_ready held 0 for 3 cycles -> outputs stable.
- wb_valid pulsed during WAIT -> spurious_wb=1, instret unchanged. Reset asserted during WAIT, then rsp arrives in FETCH -> response ignored, fetch restarts at RESET_PC.
